// File: rtl/uart_frame_tx.sv
// uart_frame_tx: FIFO-buffered multi-byte UART frame transmitter.
// Define UART_FRAME_TX_CKSUM_EN to append an XOR checksum byte per frame.
module uart_frame_tx #(
  parameter int SYS_CLK    = 50000000,
  parameter int BPS        = 115200,
  parameter int NUM_BYTES  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BYTES*8-1:0] frame_in,
  input  logic                   frame_valid,
  input  logic                   start,
  output logic                   tx,
  output logic                   busy,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   frame_done
);
  localparam int BIT_CYCLES = SYS_CLK / BPS;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = NUM_BYTES * 8;
`ifdef UART_FRAME_TX_CKSUM_EN
  localparam int NB_TX = NUM_BYTES + 1;
`else
  localparam int NB_TX = NUM_BYTES;
`endif
  localparam int SW = NB_TX * 8;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, DATA, STOP
  } state_e;

  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   fcnt_q;
  logic          ovf_q;
  logic          push, pop, empty;
  logic [FW-1:0] head;
  logic [SW-1:0] load_w;

  state_e        st_q;
  logic [CW-1:0] bc_q;
  logic [2:0]    bit_q;
  logic [BW-1:0] byte_q;
  logic [SW-1:0] sh_q;
  logic          tx_q, busy_q, done_q;
  logic          bit_end, last_byte, chain;

  assign fifo_full = (fcnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (fcnt_q == '0);
  assign push      = frame_valid && !fifo_full;
  assign head      = mem_q[rd_q];

`ifdef UART_FRAME_TX_CKSUM_EN
  logic [7:0] ck;
  always_comb begin
    ck = '0;
    for (int k = 0; k < NUM_BYTES; k++)
      ck ^= head[8*k +: 8];
  end
  assign load_w = {ck, head};
`else
  assign load_w = head;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= frame_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= frame_valid && fifo_full;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      fcnt_q <= fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign bit_end   = (bc_q == CW'(BIT_CYCLES - 1));
  assign last_byte = (byte_q == BW'(NB_TX - 1));
  // Next frame is popped straight out of STOP so frames run back-to-back.
  assign chain = (st_q == STOP) && bit_end && last_byte
              && start && !empty;
  assign pop = (st_q == LOAD) || chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      bc_q   <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      sh_q   <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        IDLE: if (start && !empty) st_q <= LOAD;
        LOAD: begin
          sh_q   <= load_w;
          tx_q   <= 1'b0;
          busy_q <= 1'b1;
          bc_q   <= '0;
          byte_q <= '0;
          st_q   <= START;
        end
        START: begin
          if (bit_end) begin
            bc_q  <= '0;
            bit_q <= '0;
            tx_q  <= sh_q[0];
            sh_q  <= sh_q >> 1;
            st_q  <= DATA;
          end else bc_q <= bc_q + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            bc_q  <= '0;
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              tx_q <= 1'b1;
              st_q <= STOP;
            end else begin
              tx_q <= sh_q[0];
              sh_q <= sh_q >> 1;
            end
          end else bc_q <= bc_q + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            bc_q <= '0;
            if (!last_byte) begin
              byte_q <= byte_q + 1'b1;
              tx_q   <= 1'b0;
              st_q   <= START;
            end else begin
              done_q <= 1'b1;
              byte_q <= '0;
              if (chain) begin
                sh_q <= load_w;
                tx_q <= 1'b0;
                st_q <= START;
              end else begin
                busy_q <= 1'b0;
                st_q   <= IDLE;
              end
            end
          end else bc_q <= bc_q + 1'b1;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign frame_done = done_q;
endmodule
